// File: rtl/pix_clk_pkg.sv
// rtl/pix_clk_pkg.sv - shared types and default constants for the pixel clock generator
package pix_clk_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUN     = 1'b1
    } state_t;

    localparam int CNT_W_DEF       = 8;
    localparam int DEFAULT_DIV_DEF = 10;

endpackage

// File: rtl/pix_clk_gen_if.sv
// rtl/pix_clk_gen_if.sv - run/divisor handshake and clock outputs of pix_clk_gen
// master: drives en, div_in, div_valid; observes div_ready, div_err, clk_pix, pix_ce, cur_div, running
// slave : the generator side of the same signals
interface pix_clk_gen_if #(
    parameter int CNT_W = pix_clk_pkg::CNT_W_DEF
);
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             div_err;
    logic             clk_pix;
    logic             pix_ce;
    logic [CNT_W-1:0] cur_div;
    logic             running;

    modport master (
        output en, div_in, div_valid,
        input  div_ready, div_err, clk_pix, pix_ce, cur_div, running
    );

    modport slave (
        input  en, div_in, div_valid,
        output div_ready, div_err, clk_pix, pix_ce, cur_div, running
    );
endinterface

// File: rtl/pix_clk_gen.sv
// rtl/pix_clk_gen.sv - programmable integer divider producing a pixel clock and clock enable
// Ports: clk, rst (sync, active-high), bus (pix_clk_gen_if.slave):
//   en        run request, stop takes effect at the end of the current period
//   div_in/div_valid/div_ready  divisor offer handshake (ready = no divisor pending)
//   div_err   one-cycle pulse when a divisor below 2 is offered
//   clk_pix   divided clock, high for ceil(cur_div/2) cycles per period
//   pix_ce    high in the first cycle of each clk_pix period
//   cur_div   divisor in effect, running = generator active
module pix_clk_gen
    import pix_clk_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic           clk,
    input  logic           rst,
    pix_clk_gen_if.slave   bus
);

    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TWO   = CNT_W'(2);
    localparam logic [CNT_W:0]   C_ONE_W = (CNT_W+1)'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend_valid;
    logic             r_clk_pix;
    logic             r_pix_ce;
    logic             r_div_err;
    logic             r_running;
    logic             r_div_ready;

    logic             w_accept;
    logic             w_legal;
    logic             w_wrap;
    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_div_nx;
    logic [CNT_W-1:0] w_pend_div_nx;
    logic             w_pend_valid_nx;
    logic [CNT_W:0]   w_hi_nx;

    always_comb begin
        w_accept        = bus.div_valid && !r_pend_valid;
        w_legal         = (bus.div_in >= C_TWO);
        w_wrap          = (r_cnt == (r_cur_div - C_ONE));
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_div_nx        = r_cur_div;
        w_pend_div_nx   = r_pend_div;
        w_pend_valid_nx = r_pend_valid;

        case (r_state)
            STOPPED: begin
                // No period in flight, so a new divisor can take effect at once.
                w_cnt_nx = '0;
                if (w_accept && w_legal) begin
                    w_div_nx = bus.div_in;
                end
                if (bus.en) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (w_wrap) begin
                    w_cnt_nx = '0;
                    if (r_pend_valid) begin
                        w_div_nx        = r_pend_div;
                        w_pend_valid_nx = 1'b0;
                    end
                    // An offer landing on the wrap itself waits for the following wrap.
                    if (w_accept && w_legal) begin
                        w_pend_div_nx   = bus.div_in;
                        w_pend_valid_nx = 1'b1;
                    end
                    if (!bus.en) begin
                        w_state_nx = STOPPED;
                    end
                end else begin
                    w_cnt_nx = r_cnt + C_ONE;
                    if (w_accept && w_legal) begin
                        w_pend_div_nx   = bus.div_in;
                        w_pend_valid_nx = 1'b1;
                    end
                end
            end
            default: w_state_nx = STOPPED;
        endcase

        // High phase length; the extra bit keeps cur_div+1 from overflowing.
        w_hi_nx = ({1'b0, w_div_nx} + C_ONE_W) >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= STOPPED;
            r_cnt        <= '0;
            r_cur_div    <= CNT_W'(DEFAULT_DIV);
            r_pend_div   <= '0;
            r_pend_valid <= 1'b0;
            r_clk_pix    <= 1'b0;
            r_pix_ce     <= 1'b0;
            r_div_err    <= 1'b0;
            r_running    <= 1'b0;
            r_div_ready  <= 1'b1;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_cur_div    <= w_div_nx;
            r_pend_div   <= w_pend_div_nx;
            r_pend_valid <= w_pend_valid_nx;
            r_running    <= (w_state_nx == RUN);
            r_pix_ce     <= (w_state_nx == RUN) && (w_cnt_nx == '0);
            r_clk_pix    <= (w_state_nx == RUN) && ({1'b0, w_cnt_nx} < w_hi_nx);
            r_div_err    <= w_accept && !w_legal;
            r_div_ready  <= !w_pend_valid_nx;
        end
    end

    assign bus.div_ready = r_div_ready;
    assign bus.div_err   = r_div_err;
    assign bus.clk_pix   = r_clk_pix;
    assign bus.pix_ce    = r_pix_ce;
    assign bus.cur_div   = r_cur_div;
    assign bus.running   = r_running;

endmodule

// File: doc/pix_clk_gen.md
PIX_CLK_GEN -- requirements
Module: pix_clk_gen

Interface
REQ-001 Parameter CNT_W, default 8, width of divisor and period counter.
REQ-002 Parameter DEFAULT_DIV, default 10, divisor in effect after reset; SHALL be in range 2..2^CNT_W-1.
REQ-003 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  run request; high starts or keeps the generator running.
REQ-006 div_in  input  CNT_W  requested divisor, i.e. the output period in clk cycles.
REQ-007 div_valid  input  1  div_in offered this cycle.
REQ-008 div_ready  output  1  a divisor can be accepted this cycle.
REQ-009 div_err  output  1  one-cycle pulse when an illegal divisor is offered.
REQ-010 clk_pix  output  1  divided pixel clock, registered.
REQ-011 pix_ce  output  1  one-cycle clock enable, high in the first cycle of each clk_pix period.
REQ-012 cur_div  output  CNT_W  divisor currently in effect.
REQ-013 running  output  1  high while in state RUN.

Function
REQ-014 The block SHALL have two states, STOPPED and RUN, plus a period counter cnt and a pending-divisor register with a valid flag.
REQ-015 STOPPED to RUN: when en=1, in the next cycle cnt=0, clk_pix=1 and pix_ce=1.
REQ-016 In RUN, cnt SHALL increment each cycle and wrap to 0 after cur_div-1; one period SHALL be exactly cur_div clk cycles.
REQ-017 clk_pix SHALL be high for cnt in 0..hi-1 and low otherwise, where hi=(cur_div+1)>>1.
REQ-018 Even divisors SHALL give a 50% duty cycle; odd divisors SHALL be high one cycle longer than low.
REQ-019 pix_ce SHALL be high exactly in the cycles where cnt=0 in RUN, and low in STOPPED.
REQ-020 All outputs SHALL be registered; clk_pix and pix_ce SHALL be computed from the next-state cnt and divisor.
REQ-021 A divisor is accepted when div_valid=1 and div_ready=1; div_ready SHALL equal NOT pending_valid.
REQ-022 If div_in<2 while div_valid=1 and div_ready=1, the offer SHALL NOT be stored and div_err SHALL pulse high for one cycle.
REQ-023 In RUN, an accepted divisor SHALL become pending and be applied only at the next wrap strictly after the accept cycle.
REQ-024 At that wrap cur_div SHALL update, pending_valid SHALL clear and the new period SHALL start; there SHALL be no truncated or glitched clk_pix period.
REQ-025 If an accept and a wrap occur in the same cycle, the wrap SHALL keep the old divisor and the new value SHALL become pending.
REQ-026 In STOPPED, an accepted divisor SHALL be written to cur_div in the next cycle; div_ready SHALL stay high.
REQ-027 en=0 in RUN SHALL take effect at the next wrap: the current period completes, then the state becomes STOPPED with clk_pix=0 and pix_ce=0.
REQ-028 If en=0 and a pending divisor exist at the same wrap, the pending divisor SHALL still be applied to cur_div.
REQ-029 If en returns to 1 before that wrap, the generator SHALL keep running with no interruption.

Reset
REQ-030 On rst: state STOPPED, cnt=0, cur_div=DEFAULT_DIV, pending_valid=0, clk_pix=0, pix_ce=0, div_err=0, running=0, div_ready=1.
REQ-031 rst SHALL override all other inputs and discard any pending divisor, including a reset in mid-period.

Structure
REQ-032 The package pix_clk_pkg SHALL hold the state enum (STOPPED, RUN) and the default constants CNT_W_DEF=8 and DEFAULT_DIV_DEF=10.
REQ-033 The block SHALL be a single module; no sub-module is required.

Verification
REQ-034 Reset, then en=1 -> clk_pix high 5 cycles and low 5 cycles repeating; pix_ce every 10 cycles; cur_div=10.
REQ-035 Accept div_in=5 while STOPPED, then en=1 -> clk_pix high 3 cycles and low 2; pix_ce period 5.
REQ-036 Running at div 10, accept 4 at cnt=3 -> current period lasts 10 cycles, then 4-cycle periods; div_ready low from the accept until that wrap.
REQ-037 Offer div_in=1 or 0 -> div_err one-cycle pulse; cur_div and the period are unchanged; div_ready stays high.
REQ-038 Drop en at cnt=2 -> the period finishes (10 cycles), then clk_pix=0, pix_ce=0, running=0; re-raise en -> restart at phase cnt=0 with a pix_ce pulse.
REQ-039 Apply rst mid-period with div 4 in effect and 7 pending -> all reset values; after en=1, period is 10.
